approx_dispatch: RTL and testbench

Buffers incoming 8-bit samples in a small FIFO and sequences them one at a time into the approximation core (`approx_top`). It drives the core's `start_i`/`x_i`/`nIt_i`, waits for `valid_o`, and presents each result with its source sample on a valid/ready output stream. A watchdog aborts jobs the core never completes. It sits directly upstream of the core and also collects the core's results.

---
 rtl/approx_dispatch_if.sv | 21 ++
 rtl/approx_dispatch.sv | 120 ++++++++++++
 tb/tb_approx_dispatch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_dispatch_if.sv
// Valid/ready streams around approx_dispatch: samples in, {sample, result} pairs out.
// The dispatcher connects through the slave modport, its upstream/downstream through master.
interface approx_dispatch_if;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_x_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_x_o;
    logic [7:0] out_y_o;

    modport slave (
        input  in_valid_i, in_x_i, out_ready_i,
        output in_ready_o, out_valid_o, out_x_o, out_y_o
    );

    modport master (
        output in_valid_i, in_x_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_x_o, out_y_o
    );
endinterface

// File: rtl/approx_dispatch.sv
// Queues 8-bit samples and feeds them one at a time to the approximation core,
// returning each result with its source sample; a watchdog drops jobs that never finish.
//
//   state | meaning
//   IDLE  | waiting for a queued sample and an idle core
//   ISSUE | start pulse out, FIFO head popped, watchdog cleared
//   WAIT  | waiting for core_valid_i, watchdog counting
//   HOLD  | result presented until the downstream takes it
module approx_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    approx_dispatch_if.slave        strm,
    input  logic [2:0]              nIt_i,
    output logic                    core_start_o,
    output logic [7:0]              core_x_o,
    output logic [2:0]              core_nIt_o,
    input  logic                    core_busy_i,
    input  logic                    core_valid_i,
    input  logic [7:0]              core_y_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [WW-1:0] wdog;
    logic          push;
    logic          pop;

    assign strm.in_ready_o = (count_o != (PW+1)'(DEPTH));
    assign push            = strm.in_valid_i && strm.in_ready_o;
    assign pop             = (state == ISSUE);

    // Storage is not reset: count_o alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= strm.in_x_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + (PW+1)'(1);
                2'b01:   count_o <= count_o - (PW+1)'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            core_start_o     <= 1'b0;
            core_x_o         <= '0;
            core_nIt_o       <= '0;
            strm.out_valid_o <= 1'b0;
            strm.out_x_o     <= '0;
            strm.out_y_o     <= '0;
            err_o            <= 1'b0;
            wdog             <= '0;
        end else begin
            core_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if ((count_o != '0) && !core_busy_i) begin
                        state        <= ISSUE;
                        core_start_o <= 1'b1;
                        core_x_o     <= mem[rd_ptr];
                        core_nIt_o   <= nIt_i;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result landing on the timeout edge still counts.
                    if (core_valid_i) begin
                        strm.out_y_o     <= core_y_i;
                        strm.out_x_o     <= core_x_o;
                        strm.out_valid_o <= 1'b1;
                        state            <= HOLD;
                    end else if (wdog == WW'(TIMEOUT)) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                HOLD: begin
                    if (strm.out_ready_i) begin
                        strm.out_valid_o <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_dispatch.sv
// Randomized bench for approx_dispatch: a cycle-level core model plus a queue-based
// reference of accepted samples, issued jobs and expected results.
module tb_approx_dispatch;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] nIt_i = '0;
    logic       core_start_o;
    logic [7:0] core_x_o;
    logic [2:0] core_nIt_o;
    logic       core_busy_i = 1'b0;
    logic       core_valid_i = 1'b0;
    logic [7:0] core_y_i = '0;
    logic [2:0] count_o;
    logic       err_o;

    approx_dispatch_if strm();

    approx_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .strm         (strm),
        .nIt_i        (nIt_i),
        .core_start_o (core_start_o),
        .core_x_o     (core_x_o),
        .core_nIt_o   (core_nIt_o),
        .core_busy_i  (core_busy_i),
        .core_valid_i (core_valid_i),
        .core_y_i     (core_y_i),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  q_in[$];
    logic [7:0]  src_q[$];
    logic [15:0] exp_q[$];
    int          lat_q[$];
    logic [7:0]  y_q[$];

    bit         job_on = 0;
    int         wait_k = 0;
    int         job_lat = 0;
    logic [7:0] job_x = '0;
    logic [7:0] job_y = '0;
    bit         idle_m = 1;
    bit         exp_start = 0;
    bit         err_exp = 0;
    bit         last_push = 0;

    int rdy_pct = 100;
    int push_pct = 100;
    bit force_busy = 0;
    bit rand_busy = 0;
    bit rand_nit = 0;
    bit glitch_en = 0;
    int n_start = 0;
    int n_result = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_count",     count_o,          0);
        chk("rst_in_ready",  strm.in_ready_o,  1);
        chk("rst_start",     core_start_o,     0);
        chk("rst_core_x",    core_x_o,         0);
        chk("rst_core_nIt",  core_nIt_o,       0);
        chk("rst_out_valid", strm.out_valid_o, 0);
        chk("rst_out_x",     strm.out_x_o,     0);
        chk("rst_out_y",     strm.out_y_o,     0);
        chk("rst_err",       err_o,            0);
    endtask

    // One clock cycle: check outputs against the model, then drive the next cycle.
    task automatic cycle();
        int  sz0;
        bit  hs;
        bit  to_idle;
        bit  rdy;
        bit  busy;
        @(negedge clk);
        sz0 = q_in.size();
        chk("count",     count_o,          sz0);
        chk("in_ready",  strm.in_ready_o,  sz0 != DEPTH);
        chk("err",       err_o,            err_exp);
        chk("start",     core_start_o,     exp_start);
        chk("out_valid", strm.out_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("out_x", strm.out_x_o, exp_q[0][15:8]);
            chk("out_y", strm.out_y_o, exp_q[0][7:0]);
        end

        if (core_start_o) begin
            n_start++;
            chk("start_has_sample", sz0 != 0, 1);
            chk("start_no_overlap", job_on, 0);
            if (sz0 != 0) begin
                chk("core_x", core_x_o, q_in[0]);
                job_x = q_in.pop_front();
            end
            chk("core_nIt", core_nIt_o, nIt_i);
            job_on = 1;
            wait_k = 0;
            if (lat_q.size() != 0) job_lat = lat_q.pop_front();
            else job_lat = int'($urandom_range(1, TIMEOUT + 3));
            if (y_q.size() != 0) job_y = y_q.pop_front();
            else job_y = 8'($urandom);
        end

        rdy = (int'($urandom_range(0, 99)) < rdy_pct);
        strm.out_ready_i = rdy;
        hs = (exp_q.size() != 0) && rdy;
        if (hs) begin
            void'(exp_q.pop_front());
            n_result++;
        end

        to_idle = 0;
        core_valid_i = 1'b0;
        core_y_i = 8'($urandom);
        if (job_on && !core_start_o) begin
            wait_k++;
            if (wait_k == job_lat) begin
                core_valid_i = 1'b1;
                core_y_i = job_y;
                exp_q.push_back({job_x, job_y});
                job_on = 0;
            end else if (wait_k == TIMEOUT + 1) begin
                err_exp = 1;
                job_on = 0;
                to_idle = 1;
            end
        end else if (!job_on && glitch_en) begin
            core_valid_i = ($urandom_range(0, 5) == 0);
        end

        busy = job_on || force_busy || (rand_busy && ($urandom_range(0, 3) == 0));
        core_busy_i = busy;
        exp_start = 0;
        if (idle_m && (q_in.size() != 0) && !busy) begin
            exp_start = 1;
            idle_m = 0;
        end else if (hs || to_idle) begin
            idle_m = 1;
        end

        if (!strm.in_valid_i || last_push) begin
            if ((src_q.size() != 0) && (int'($urandom_range(0, 99)) < push_pct)) begin
                strm.in_valid_i = 1'b1;
                strm.in_x_i = src_q.pop_front();
            end else begin
                strm.in_valid_i = 1'b0;
            end
        end
        last_push = strm.in_valid_i && (sz0 != DEPTH);
        if (last_push) q_in.push_back(strm.in_x_i);

        if (rand_nit) nIt_i = 3'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while (((src_q.size() != 0) || (q_in.size() != 0) || job_on || (exp_q.size() != 0) ||
                strm.in_valid_i || exp_start) && (c < maxc)) begin
            cycle();
            c++;
        end
        chk("drain_done", c < maxc, 1);
    endtask

    initial begin
        int s0;
        int r0;
        strm.in_valid_i = 1'b0;
        strm.in_x_i = '0;
        strm.out_ready_i = 1'b0;

        repeat (8) @(posedge clk);
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b1;

        // single job
        nIt_i = 3'd5;
        src_q.push_back(8'd19);
        lat_q.push_back(11);
        y_q.push_back(8'h2A);
        rdy_pct = 0;
        run(25);
        chk("single_starts", n_start, 1);
        chk("single_held", strm.out_valid_o, 1);
        rdy_pct = 100;
        drain(50);
        chk("single_results", n_result, 1);
        chk("single_count", count_o, 0);

        // fill while core busy, then release six jobs
        force_busy = 1;
        for (int i = 1; i <= 5; i++) src_q.push_back(8'(i));
        run(10);
        chk("full_count", count_o, 4);
        chk("full_ready", strm.in_ready_o, 0);
        src_q.push_back(8'd6);
        r0 = n_result;
        force_busy = 0;
        for (int i = 0; i < 6; i++) lat_q.push_back(i + 1);
        drain(200);
        chk("full_results", n_result - r0, 6);

        // output backpressure
        rdy_pct = 0;
        for (int i = 0; i < 3; i++) begin
            src_q.push_back(8'(8'hA0 + i));
            lat_q.push_back(3);
        end
        s0 = n_start;
        run(20);
        chk("bp_one_start", n_start - s0, 1);
        chk("bp_held", strm.out_valid_o, 1);
        rdy_pct = 100;
        drain(100);

        // result on the timeout edge
        r0 = n_result;
        src_q.push_back(8'd77);
        lat_q.push_back(TIMEOUT + 1);
        drain(100);
        chk("edge_result", n_result - r0, 1);
        chk("edge_no_err", err_o, 0);

        // watchdog abort followed by a normal job
        r0 = n_result;
        src_q.push_back(8'h10);
        src_q.push_back(8'h11);
        lat_q.push_back(0);
        lat_q.push_back(4);
        drain(200);
        chk("to_err", err_o, 1);
        chk("to_results", n_result - r0, 1);

        // randomized traffic
        rand_nit = 1;
        glitch_en = 1;
        rand_busy = 1;
        rdy_pct = 60;
        push_pct = 70;
        r0 = n_result;
        for (int i = 0; i < 200; i++) src_q.push_back(8'($urandom));
        drain(8000);
        chk("rand_progress", n_result - r0 > 100, 1);

        // reset in the middle of a job
        rand_nit = 0;
        glitch_en = 0;
        rand_busy = 0;
        rdy_pct = 100;
        push_pct = 100;
        lat_q.push_back(0);
        for (int i = 0; i < 3; i++) src_q.push_back(8'(8'h50 + i));
        for (int i = 0; i < 60 && !(job_on && wait_k >= 5); i++) cycle();
        chk("mid_in_wait", job_on && (wait_k >= 5), 1);
        #2 rst = 1'b0;
        #1 chk_reset();
        q_in.delete();
        src_q.delete();
        exp_q.delete();
        lat_q.delete();
        y_q.delete();
        job_on = 0;
        idle_m = 1;
        exp_start = 0;
        err_exp = 0;
        last_push = 0;
        strm.in_valid_i = 1'b0;
        core_valid_i = 1'b0;
        core_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        s0 = n_start;
        run(30);
        chk("post_rst_no_start", n_start - s0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
